// File: rtl/mem_store_if.sv
// Request/RAM-write bundle for mem_store: store request inputs, RAM byte port
// and status outputs, with the requester as master and mem_store as slave.
interface mem_store_if #(
  parameter int RAM_ADDR_WIDTH = 17
);
  logic                      rdy;
  logic                      start_i;
  logic [1:0]                size_i;
  logic [31:0]               addr_i;
  logic [31:0]               data_i;
  logic                      we_RAM_o;
  logic [RAM_ADDR_WIDTH-1:0] waddr_RAM_o;
  logic [7:0]                wdata_RAM_o;
  logic                      busy_o;
  logic                      done_o;

  modport master (
    output rdy, start_i, size_i, addr_i, data_i,
    input  we_RAM_o, waddr_RAM_o, wdata_RAM_o, busy_o, done_o
  );

  modport slave (
    input  rdy, start_i, size_i, addr_i, data_i,
    output we_RAM_o, waddr_RAM_o, wdata_RAM_o, busy_o, done_o
  );
endinterface

// File: rtl/mem_store.sv
// Splits a byte/half/word store into consecutive little-endian RAM byte writes,
// freezing on rdy=0 and pulsing done_o once per request.
module mem_store #(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input logic        clk,
  input logic        rst,
  mem_store_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                r_state;
  logic [1:0]                r_k;
  logic [1:0]                r_last;
  logic [RAM_ADDR_WIDTH-1:0] r_base;
  logic [31:0]               r_data;

  logic                      w_inWrite;
  logic [RAM_ADDR_WIDTH-1:0] w_waddr;
  logic [7:0]                w_byte;

  // r_last holds N-1 so the final byte is recognised without a full count
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= 2'd0;
      r_last  <= 2'd0;
      r_base  <= '0;
      r_data  <= 32'h0;
    end else if (bus.rdy) begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            if (bus.size_i == 2'b11) begin
              r_state <= S_DONE;
            end else begin
              r_base  <= bus.addr_i[RAM_ADDR_WIDTH-1:0];
              r_data  <= bus.data_i;
              r_k     <= 2'd0;
              r_last  <= (bus.size_i == 2'b00) ? 2'd0 :
                         (bus.size_i == 2'b01) ? 2'd1 : 2'd3;
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_k <= r_k + 2'd1;
          if (r_k == r_last) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_byte = r_data[7:0];
    case (r_k)
      2'd1:    w_byte = r_data[15:8];
      2'd2:    w_byte = r_data[23:16];
      2'd3:    w_byte = r_data[31:24];
      default: w_byte = r_data[7:0];
    endcase
  end

  // Address sum wraps naturally at the RAM size
  assign w_inWrite       = (r_state == S_WRITE);
  assign w_waddr         = r_base + {{(RAM_ADDR_WIDTH-2){1'b0}}, r_k};
  assign bus.we_RAM_o    = w_inWrite & bus.rdy;
  assign bus.waddr_RAM_o = w_inWrite ? w_waddr : '0;
  assign bus.wdata_RAM_o = w_inWrite ? w_byte : 8'h00;
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.done_o      = (r_state == S_DONE) & bus.rdy;
endmodule

// File: doc/mem_store.md
MEM_STORE -- requirements
Module: mem_store

Interface
REQ-001 Parameter RAM_ADDR_WIDTH, default 17, sets the width of the RAM byte address (128 KiB RAM).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 rdy  input  1  global ready; 0 freezes the block.
REQ-005 start_i  input  1  store request; honoured only in IDLE.
REQ-006 size_i  input  2  store size: 00 byte (SB), 01 half (SH), 10 word (SW), 11 reserved.
REQ-007 addr_i  input  32  store byte address.
REQ-008 data_i  input  32  store data, little-endian.
REQ-009 we_RAM_o  output  1  RAM byte write enable.
REQ-010 waddr_RAM_o  output  RAM_ADDR_WIDTH  RAM byte address.
REQ-011 wdata_RAM_o  output  8  RAM write byte.
REQ-012 busy_o  output  1  high whenever state is not IDLE.
REQ-013 done_o  output  1  one-cycle completion pulse.

Function
REQ-014 FSM states IDLE, WRITE, DONE; every transition is gated by rdy=1.
REQ-015 IDLE: on start_i=1, latch addr_i[RAM_ADDR_WIDTH-1:0], data_i and byte count N (1/2/4 for size 00/01/10); clear byte index k; go to WRITE; size 11 latches nothing and goes to DONE.
REQ-016 WRITE: we_RAM_o=1, waddr_RAM_o=base+k mod 2^RAM_ADDR_WIDTH, wdata_RAM_o=data[8k+7:8k]; k increments each rdy cycle; after byte k=N-1, go to DONE.
REQ-017 Exactly N write cycles per request; bytes emitted in ascending order k=0..N-1.
REQ-018 Address arithmetic wraps at 2^RAM_ADDR_WIDTH; no alignment check; misaligned stores allowed.
REQ-019 DONE: done_o=1 for exactly one cycle, then IDLE; start_i ignored in DONE.
REQ-020 Latency: start sampled at edge T gives first write during cycle T+1, last at T+N, done_o during T+N+1, start accepted again at edge T+N+1 (with rdy=1 throughout).
REQ-021 start_i while busy is ignored; latched operands unaffected by input changes during a request.
REQ-022 rdy=0: state, k and latched operands hold; we_RAM_o and done_o forced 0 (combinational gating); waddr/wdata hold values.
REQ-023 Outside WRITE, we_RAM_o=0 and wdata_RAM_o=0.
REQ-024 rdy=0 in IDLE: start_i not accepted.

Reset
REQ-025 rst=0 at a rising edge forces IDLE, k=0, latched operands 0, we_RAM_o=0, waddr_RAM_o=0, wdata_RAM_o=0, busy_o=0, done_o=0.
REQ-026 Reset mid-WRITE aborts the store with no further writes and no done_o pulse; reset dominates start_i and rdy.
REQ-027 First start accepted at the first edge with rst=1, rdy=1, start_i=1.

Verification
REQ-028 SW: addr 0x00000100, data 0xAABBCCDD -> writes DD@0x100, CC@0x101, BB@0x102, AA@0x103 on consecutive cycles; done_o on 5th cycle after start.
REQ-029 SB/SH: SB addr 0x5, data 0x12345678 -> single write 78@0x5; SH addr 0x6 -> 78@0x6, 56@0x7; each followed by one-cycle done_o.
REQ-030 Wrap: SW addr 0x0001FFFE (width 17), data 0x11223344 -> 44@0x1FFFE, 33@0x1FFFF, 22@0x00000, 11@0x00001.
REQ-031 Stall: SW with rdy=0 for 3 cycles after byte 1 -> we_RAM_o low during stall; bytes 2,3 resume in order; exactly 4 writes; done_o delayed 3 cycles.
REQ-032 Interference: start_i=1 with new data each busy cycle -> ignored, original bytes written; size 11 -> no writes, done_o one cycle after start.
REQ-033 Reset: rst=0 after byte 1 of SW -> outputs zero next cycle, no bytes 2-3, no done_o; a fresh SB afterwards completes normally.
